// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC sequencer: controller state encoding,
// default iteration parameters and the rotation/vectoring mode encoding.
// -----------------------------------------------------------------------------
package cordic_pkg;

  // Controller states: wait, operand load, micro-rotation steps, result hold.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CORDIC_N_ITER = 16;
  localparam int CORDIC_ITER_W = 6;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage : cordic_pkg

// File: rtl/cordic_ctrl_if.sv
// -----------------------------------------------------------------------------
// cordic_ctrl_if
// Handshake and datapath-control bundle between the host/datapath side
// (master) and the CORDIC sequencer (slave).
//   master drives : start, mode, z_sign, y_sign, ack
//   slave drives  : load, en, iter[ITER_W], dir, busy, done
// -----------------------------------------------------------------------------
interface cordic_ctrl_if
  import cordic_pkg::*;
#(
  parameter int ITER_W = CORDIC_ITER_W
);

  logic              start;
  logic              mode;
  logic              z_sign;
  logic              y_sign;
  logic              ack;
  logic              load;
  logic              en;
  logic [ITER_W-1:0] iter;
  logic              dir;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, z_sign, y_sign, ack,
    input  load, en, iter, dir, busy, done
  );

  modport slave (
    input  start, mode, z_sign, y_sign, ack,
    output load, en, iter, dir, busy, done
  );

endinterface : cordic_ctrl_if

// File: rtl/cordic_iter_cnt.sv
// -----------------------------------------------------------------------------
// cordic_iter_cnt
// Iteration index counter for the CORDIC sequencer.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear to 0 (wins over i_en)
//   i_en      : increment by one
//   o_count   : current index (shift amount / atan LUT address)
//   o_tc      : terminal count, high when o_count == N_ITER-1
// -----------------------------------------------------------------------------
module cordic_iter_cnt
  import cordic_pkg::*;
#(
  parameter int N_ITER = CORDIC_N_ITER,
  parameter int ITER_W = CORDIC_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ITER_W-1:0] o_count,
  output logic              o_tc
);

  localparam logic [ITER_W-1:0] TC_VAL = ITER_W'(N_ITER - 1);

  logic [ITER_W-1:0] r_count;

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ITER_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == TC_VAL);

endmodule : cordic_iter_cnt

// File: rtl/cordic_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_ctrl
// Sequencer for the iterative CORDIC datapath. A start request in IDLE issues
// a one-cycle operand-load strobe, then N_ITER enable cycles with the
// iteration index and rotation direction, then holds done until ack.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.start  : operation request (seen only in IDLE)
//   bus.mode   : 0 rotation / 1 vectoring, captured with start
//   bus.z_sign : sign of datapath z register (rotation direction source)
//   bus.y_sign : sign of datapath y register (vectoring direction source)
//   bus.ack    : result taken (seen only in DONE)
//   bus.load   : operand load strobe
//   bus.en     : one micro-rotation this cycle
//   bus.iter   : iteration index / shift amount / LUT address
//   bus.dir    : 1 add, 0 subtract (combinational from the sign inputs)
//   bus.busy   : operation in progress or result pending
//   bus.done   : result valid
// -----------------------------------------------------------------------------
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER = CORDIC_N_ITER,
  parameter int ITER_W = CORDIC_ITER_W
) (
  input logic          clk,
  input logic          rst,
  cordic_ctrl_if.slave bus
);

  state_e            r_state;
  logic              r_mode;
  logic              r_load;
  logic              r_en;
  logic              r_busy;
  logic              r_done;

  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_tc;
  logic [ITER_W-1:0] w_iter;

  // The index is cleared on the edge that enters LOAD, and only advances in
  // ITER below the terminal count, so it parks at N_ITER-1 through DONE.
  assign w_cnt_clr = (r_state == IDLE) && bus.start;
  assign w_cnt_en  = (r_state == ITER) && !w_tc;

  cordic_iter_cnt #(
    .N_ITER (N_ITER),
    .ITER_W (ITER_W)
  ) u_iter_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_iter),
    .o_tc    (w_tc)
  );

  // Output flags are registered alongside the state so each one is a clean
  // flop output that mirrors the state it decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_ROT;
      r_load  <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= LOAD;
            r_mode  <= bus.mode;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_state <= ITER;
          r_load  <= 1'b0;
          r_en    <= 1'b1;
        end
        ITER: begin
          if (w_tc) begin
            r_state <= DONE;
            r_en    <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ack) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.load = r_load;
  assign bus.en   = r_en;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.iter = w_iter;

  // Same-cycle response to the datapath sign bits; forced low outside ITER.
  assign bus.dir  = r_en & ((r_mode == MODE_VEC) ? bus.y_sign : ~bus.z_sign);

endmodule : cordic_ctrl

// File: tb/tb_cordic_ctrl.sv
module tb_cordic_ctrl;
  import cordic_pkg::*;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_ctrl_if #(.ITER_W(6)) bus ();
  cordic_ctrl_if #(.ITER_W(1)) bus1 ();

  cordic_ctrl #(.N_ITER(N), .ITER_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  cordic_ctrl #(.N_ITER(1), .ITER_W(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation is a timeline counted in edges since the
  // accepted start edge (t=0 load, t=1..N steps, t>N result held until ack).
  bit m_active = 1'b0;
  int m_t      = 0;
  bit m_mode   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_mode   <= 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_mode   <= bus.mode;
      end
    end else if (m_t > N && bus.ack) begin
      m_active <= 1'b0;
    end else if (m_t <= N) begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit exp_load = m_active && (m_t == 0);
      automatic bit exp_en   = m_active && (m_t >= 1) && (m_t <= N);
      automatic bit exp_done = m_active && (m_t > N);
      automatic int exp_iter = (m_t == 0) ? 0 : ((m_t <= N) ? m_t - 1 : N - 1);
      automatic bit exp_dir  = exp_en ? (m_mode ? bus.y_sign : ~bus.z_sign) : 1'b0;
      check("load", 32'(bus.load), 32'(exp_load));
      check("en",   32'(bus.en),   32'(exp_en));
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(exp_done));
      check("dir",  32'(bus.dir),  32'(exp_dir));
      if (m_active) check("iter", 32'(bus.iter), 32'(exp_iter));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from the current cycle; returns edge index of done and
  // counts of load/en/dir-high cycles. y_sign toggles every cycle.
  task automatic run_op(input bit mode, input bit disturb, input int hold,
                        input bit ack_with_start, output int done_k,
                        output int load_n, output int en_n, output int dir_n);
    int k;
    done_k = -1; load_n = 0; en_n = 0; dir_n = 0;
    bus.start = 1'b1;
    bus.mode  = mode;
    step();
    bus.start = 1'b0;
    bus.mode  = ~mode;
    k = 0;
    while (done_k < 0 && k < 100) begin
      if (bus.load) load_n++;
      if (bus.en) en_n++;
      if (bus.en && bus.dir) dir_n++;
      if (bus.done) done_k = k;
      if (disturb && (k == 4)) check("iter_at_pulse3", 32'(bus.iter), 32'd3);
      if (disturb && (k == 11)) check("iter_at_pulse10", 32'(bus.iter), 32'd10);
      if (done_k < 0) begin
        bus.start  = disturb && (k == 4 || k == 11);
        bus.ack    = disturb && (k == 7);
        bus.y_sign = ~bus.y_sign;
        step();
        k++;
      end
    end
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    for (int i = 0; i < hold; i++) step();
    check("hold_done", 32'(bus.done), 32'd1);
    check("hold_busy", 32'(bus.busy), 32'd1);
    check("hold_iter", 32'(bus.iter), 32'(N - 1));
    bus.ack   = 1'b1;
    bus.start = ack_with_start;
    step();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check("idle_after_ack", 32'(bus.busy), 32'd0);
  endtask

  int  done_k, load_n, en_n, dir_n;
  bit  found;

  initial begin
    {bus.start, bus.mode, bus.z_sign, bus.y_sign, bus.ack} = '0;
    {bus1.start, bus1.mode, bus1.z_sign, bus1.y_sign, bus1.ack} = '0;

    // Reset for 10 ns; outputs must be 0 while held.
    #1 rst = 1'b1;
    #2;
    check("rst_load", 32'(bus.load), 32'd0);
    check("rst_en",   32'(bus.en),   32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_iter", 32'(bus.iter), 32'd0);
    check("rst_dir",  32'(bus.dir),  32'd0);
    #8 rst = 1'b0;
    step();

    // Single rotation, z_sign=0: dir=1 for all 16 steps.
    bus.z_sign = 1'b0;
    run_op(MODE_ROT, 1'b0, 3, 1'b0, done_k, load_n, en_n, dir_n);
    check("rot_done_edge", 32'(done_k), 32'd17);
    check("rot_load_cycles", 32'(load_n), 32'd1);
    check("rot_en_cycles", 32'(en_n), 32'd16);
    check("rot_dir_cycles", 32'(dir_n), 32'd16);

    // Vectoring with y_sign alternating: dir follows it, 8 of 16 high.
    step();
    run_op(MODE_VEC, 1'b0, 0, 1'b0, done_k, load_n, en_n, dir_n);
    check("vec_done_edge", 32'(done_k), 32'd17);
    check("vec_dir_cycles", 32'(dir_n), 32'd8);

    // Start pulses at iter 3 and 10, ack pulse during ITER: all ignored.
    step();
    run_op(MODE_ROT, 1'b1, 1, 1'b0, done_k, load_n, en_n, dir_n);
    check("ign_done_edge", 32'(done_k), 32'd17);
    check("ign_load_cycles", 32'(load_n), 32'd1);
    check("ign_en_cycles", 32'(en_n), 32'd16);

    // Back-pressure for 20 cycles, ack together with start, then restart.
    step();
    run_op(MODE_ROT, 1'b0, 20, 1'b1, done_k, load_n, en_n, dir_n);
    run_op(MODE_ROT, 1'b0, 0, 1'b0, done_k, load_n, en_n, dir_n);
    check("restart_done_edge", 32'(done_k), 32'd17);
    check("restart_load_cycles", 32'(load_n), 32'd1);

    // Asynchronous reset mid-ITER at iter=7, between edges.
    step();
    bus.z_sign = 1'b0;
    bus.start  = 1'b1;
    bus.mode   = MODE_ROT;
    step();
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.en && bus.iter == 6'd7) found = 1'b1;
      else step();
    end
    check("reach_iter7", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_load", 32'(bus.load), 32'd0);
    check("arst_en",   32'(bus.en),   32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_iter", 32'(bus.iter), 32'd0);
    check("arst_dir",  32'(bus.dir),  32'd0);
    #2 rst = 1'b0;
    step();
    run_op(MODE_ROT, 1'b0, 0, 1'b0, done_k, load_n, en_n, dir_n);
    check("post_rst_done_edge", 32'(done_k), 32'd17);
    check("post_rst_en_cycles", 32'(en_n), 32'd16);

    // N_ITER=1 corner: load, one en cycle with iter=0, done 2 cycles after start.
    bus1.start  = 1'b1;
    bus1.mode   = MODE_ROT;
    bus1.z_sign = 1'b0;
    step();
    bus1.start = 1'b0;
    check("n1_load", 32'(bus1.load), 32'd1);
    check("n1_load_en", 32'(bus1.en), 32'd0);
    step();
    check("n1_en", 32'(bus1.en), 32'd1);
    check("n1_iter", 32'(bus1.iter), 32'd0);
    check("n1_dir", 32'(bus1.dir), 32'd1);
    check("n1_en_done", 32'(bus1.done), 32'd0);
    step();
    check("n1_done", 32'(bus1.done), 32'd1);
    check("n1_done_en", 32'(bus1.en), 32'd0);
    check("n1_done_dir", 32'(bus1.dir), 32'd0);
    bus1.ack = 1'b1;
    step();
    bus1.ack = 1'b0;
    check("n1_idle", 32'(bus1.busy), 32'd0);

    // Randomised traffic checked every cycle by the model.
    for (int i = 0; i < 2000; i++) begin
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.mode   = 1'($urandom);
      bus.z_sign = 1'($urandom);
      bus.y_sign = 1'($urandom);
      bus.ack    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cordic_ctrl

// File: doc/cordic_ctrl.md
# cordic_ctrl

Sequencer for the iterative CORDIC datapath. It accepts a start request, issues a one-cycle operand-load strobe, then steps the datapath through N_ITER micro-rotations. On each step it drives the iteration index, used as the shift amount and atan-LUT address, and the rotation direction. It holds a done/valid result until the consumer acknowledges it. The block sits between the host interface and the x/y/z shift-add datapath, and it is the only block that drives the datapath's load and enable pins.

## Interface
Parameters:
- N_ITER, 16, number of micro-rotations per operation; legal range 1..2**ITER_W.
- ITER_W, 6, width of the iteration index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- mode  in  1  0 = rotation, 1 = vectoring; captured on the start edge.
- z_sign  in  1  sign bit of the datapath z register (1 = negative).
- y_sign  in  1  sign bit of the datapath y register (1 = negative).
- ack  in  1  consumer has taken the result; sampled only in DONE.
- load  out  1  one-cycle strobe; the datapath loads x0, y0 and z0.
- en  out  1  datapath performs one micro-rotation this cycle.
- iter  out  ITER_W  current iteration index, used as the shift amount and LUT address.
- dir  out  1  1 = add (counter-clockwise step), 0 = subtract.
- busy  out  1  high in LOAD, ITER and DONE.
- done  out  1  result valid; held until ack.

## Operation
- States:
  - IDLE: wait for start.
  - LOAD: operand load.
  - ITER: micro-rotation steps.
  - DONE: hold result for the consumer.
- Transitions:
  - IDLE to LOAD when start=1; mode is latched into mode_q.
  - LOAD to ITER unconditionally, with iter cleared to 0.
  - ITER stays in ITER while iter < N_ITER-1, and iter increments by 1 each cycle.
  - ITER to DONE when iter == N_ITER-1.
  - DONE to IDLE when ack=1.
- Output decode (Moore from state):
  - load = (state==LOAD).
  - en = (state==ITER).
  - busy = (state!=IDLE).
  - done = (state==DONE).
- Direction:
  - dir is combinational.
  - In ITER with mode_q=0 (rotation), dir = ~z_sign.
  - In ITER with mode_q=1 (vectoring), dir = y_sign.
  - dir = 0 outside ITER.
- iter:
  - Holds its last value (N_ITER-1) in DONE.
  - Is cleared to 0 on entry to LOAD.
  - Never wraps past N_ITER-1.
- Boundary conditions:
  - start while busy is ignored and not queued.
  - ack outside DONE is ignored.
  - start and ack together in DONE: ack is taken and the block goes to IDLE; start is not seen until the following cycle.
  - mode changes after the start edge have no effect on the current operation.
  - N_ITER=1: ITER lasts exactly one cycle with iter=0.
- Reset:
  - Asynchronous, at any time, including mid-ITER.
  - state = IDLE, iter = 0, mode_q = 0.
  - All outputs are 0 immediately. No partial result is flagged.

## Timing
- Start edge E0 (start=1 sampled while in IDLE):
  - load is high for the cycle after E0.
  - From edge E1 to edge EN, en is high with iter = 0..N_ITER-1, one index per cycle.
  - done rises after edge E(N_ITER+1). This is 17 cycles for N_ITER=16.
- Repeat rate:
  - ack sampled high at edge Ea returns the block to IDLE after Ea.
  - The earliest next start is sampled at Ea+1.
  - Minimum period per operation is N_ITER+3 cycles.
- dir responds in the same cycle as z_sign/y_sign. The datapath must present the sign bits of its registered values, so that no combinational loop forms.
- All outputs except dir are glitch-free state decodes.

## Structure
- Package cordic_pkg holds:
  - the state enum (IDLE, LOAD, ITER, DONE);
  - default constants CORDIC_N_ITER=16 and CORDIC_ITER_W=6;
  - the mode encoding constants MODE_ROT=0 and MODE_VEC=1.
- Sub-module cordic_iter_cnt: ITER_W-bit up-counter with synchronous clear, enable and a terminal-count flag (count == N_ITER-1). It uses the same clk/rst. It is instantiated once, and the FSM uses its terminal-count flag to leave ITER.

## Test plan
- Reset then single rotation: rst=1 for 10 ns, then start=1 for one cycle with mode=0 and z_sign=0. Expect:
  - load for exactly 1 cycle;
  - en for 16 cycles with iter 0..15 and dir=1 throughout;
  - done rising 17 cycles after the start edge and held until ack.
- Vectoring direction: mode=1, y_sign toggling every cycle during ITER. Expect dir to follow y_sign cycle by cycle, and dir=0 in LOAD and DONE.
- Ignored requests: start pulsed at iterations 3 and 10, and ack pulsed during ITER. Expect no restart, no change to iter sequencing, and done still at cycle 17.
- Back-pressure: ack withheld for 20 cycles after done. Expect done=1, busy=1 and iter=15 stable. Then ack=1 together with start=1: expect IDLE next cycle with start ignored; a start on the following cycle begins a new operation.
- Reset mid-operation: rst asserted asynchronously at iter=7, between clock edges. Expect all outputs to go to 0 immediately. After rst is released, a new start produces a full 0..15 sequence.
- Parameter corner: N_ITER=1, ITER_W=1. Expect load, then one en cycle with iter=0, then done 2 cycles after the start edge.
